m_port_ultra_point_loader: RTL and testbench

M_PORT_ULTRA_POINT_LOADER -- requirements
Module: m_port_ultra_point_loader

---
 rtl/m_port_ultra_point_loader_pkg.sv | 25 ++
 rtl/m_port_ultra_xminmax_tracker.sv | 41 ++++
 rtl/m_port_ultra_point_loader.sv | 94 +++++++++
 tb/tb_m_port_ultra_point_loader.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/m_port_ultra_point_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | m_port_ultra_point_loader_pkg                                      |
// | Shared frame geometry and loader state encodings.                  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package m_port_ultra_point_loader_pkg;

  localparam int POINT_W    = 16;
  localparam int MAX_POINTS = 256;
  localparam int COORD_W    = 8;
  localparam int IDX_W      = 8;
  localparam int FRAME_W    = POINT_W * MAX_POINTS;

  typedef logic [0:0] loaderState_t;

  localparam loaderState_t FILL = 1'b0;
  localparam loaderState_t HOLD = 1'b1;

  function automatic logic [COORD_W-1:0] pointX(input logic [POINT_W-1:0] p);
    return p[POINT_W-1 -: COORD_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/m_port_ultra_xminmax_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | m_port_ultra_xminmax_tracker                                       |
// | Tracks the min-x and max-x points of the frame being loaded.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module m_port_ultra_xminmax_tracker
  import m_port_ultra_point_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_xfer,
  input  logic               i_first,
  input  logic               i_clear,
  input  logic [POINT_W-1:0] i_point,
  output logic [POINT_W-1:0] o_minPoint,
  output logic [POINT_W-1:0] o_maxPoint
);

  logic [POINT_W-1:0] r_minPoint;
  logic [POINT_W-1:0] r_maxPoint;

  // Strict compares keep the first occurrence on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_minPoint <= '0;
      r_maxPoint <= '0;
    end else if (i_clear) begin
      r_minPoint <= '0;
      r_maxPoint <= '0;
    end else if (i_xfer) begin
      if (i_first || (pointX(i_point) < pointX(r_minPoint))) r_minPoint <= i_point;
      if (i_first || (pointX(i_point) > pointX(r_maxPoint))) r_maxPoint <= i_point;
    end
  end

  assign o_minPoint = r_minPoint;
  assign o_maxPoint = r_maxPoint;

endmodule
`default_nettype wire

// File: rtl/m_port_ultra_point_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | m_port_ultra_point_loader                                          |
// | Loads a frame of up to 256 {x,y} points and holds it until consume.|
// | Option: POINT_LOADER_XMINMAX_EN adds xMinPoint/xMaxPoint outputs.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module m_port_ultra_point_loader
  import m_port_ultra_point_loader_pkg::*;
(
  input  logic               CLK100MHZ,
  input  logic               CPU_RESET,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic               in_last,
  output logic [FRAME_W-1:0] points,
  output logic [IDX_W-1:0]   SS,
  output logic               points_valid,
`ifdef POINT_LOADER_XMINMAX_EN
  output logic [POINT_W-1:0] xMinPoint,
  output logic [POINT_W-1:0] xMaxPoint,
`endif
  input  logic               consume
);

  loaderState_t       r_state;
  loaderState_t       w_nextState;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_ss;
  logic [FRAME_W-1:0] r_points;
  logic               w_xfer;
  logic               w_exit;
  logic               w_release;

  assign w_xfer    = in_valid && in_ready;
  assign w_exit    = w_xfer && (in_last || (r_idx == IDX_W'(MAX_POINTS - 1)));
  assign w_release = (r_state == HOLD) && consume;

  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) r_state <= FILL;
    else           r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FILL:    if (w_exit)  w_nextState = HOLD;
      HOLD:    if (consume) w_nextState = FILL;
      default: w_nextState = FILL;
    endcase
  end

  always_comb begin
    in_ready     = (r_state == FILL);
    points_valid = (r_state == HOLD);
  end

  // Slot base is idx*16, formed by appending four zero bits.
  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      r_idx    <= '0;
      r_ss     <= '0;
      r_points <= '0;
    end else if (w_xfer) begin
      r_points[{r_idx, 4'h0} +: POINT_W] <= {in_x, in_y};
      r_idx <= r_idx + 1'b1;
      if (w_exit) r_ss <= r_idx + 1'b1;
    end else if (w_release) begin
      r_idx    <= '0;
      r_ss     <= '0;
      r_points <= '0;
    end
  end

  assign points = r_points;
  assign SS     = r_ss;

`ifdef POINT_LOADER_XMINMAX_EN
  m_port_ultra_xminmax_tracker u_xminmax (
    .clk        (CLK100MHZ),
    .rst        (CPU_RESET),
    .i_xfer     (w_xfer),
    .i_first    (r_idx == '0),
    .i_clear    (w_release),
    .i_point    ({in_x, in_y}),
    .o_minPoint (xMinPoint),
    .o_maxPoint (xMaxPoint)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_m_port_ultra_point_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_m_port_ultra_point_loader                                       |
// | Directed self-checking bench for the point loader.                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_m_port_ultra_point_loader;

  logic          clk = 1'b0;
  logic          rst;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [7:0]    inX = '0;
  logic [7:0]    inY = '0;
  logic          inLast = 1'b0;
  logic [4095:0] points;
  logic [7:0]    ss;
  logic          pointsValid;
  logic          consume = 1'b0;
`ifdef POINT_LOADER_XMINMAX_EN
  logic [15:0]   xMinPoint;
  logic [15:0]   xMaxPoint;
`endif

  int checks   = 0;
  int failures = 0;

  m_port_ultra_point_loader dut (
    .CLK100MHZ    (clk),
    .CPU_RESET    (rst),
    .in_valid     (inValid),
    .in_ready     (inReady),
    .in_x         (inX),
    .in_y         (inY),
    .in_last      (inLast),
    .points       (points),
    .SS           (ss),
    .points_valid (pointsValid),
`ifdef POINT_LOADER_XMINMAX_EN
    .xMinPoint    (xMinPoint),
    .xMaxPoint    (xMaxPoint),
`endif
    .consume      (consume)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic sendPoint(input logic [7:0] x, input logic [7:0] y, input logic last);
    @(negedge clk);
    inValid = 1'b1; inX = x; inY = y; inLast = last;
    @(posedge clk); #1;
    inValid = 1'b0; inLast = 1'b0;
  endtask

  task automatic pulseConsume();
    @(negedge clk);
    consume = 1'b1;
    @(posedge clk); #1;
    consume = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    #1;
    checkVal("rst_ready", inReady, 1);
    checkVal("rst_valid", pointsValid, 0);
    checkVal("rst_ss", ss, 0);
    checkVal("rst_points_zero", |points, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Basic 3-point frame
    sendPoint(8'd10, 8'd20, 1'b0);
    sendPoint(8'd5, 8'd7, 1'b0);
    checkVal("basic_mid_valid", pointsValid, 0);
    sendPoint(8'd200, 8'd1, 1'b1);
    checkVal("basic_points", points[47:0], 64'hC801_0507_0A14);
    checkVal("basic_ss", ss, 3);
    checkVal("basic_valid", pointsValid, 1);
    checkVal("basic_ready", inReady, 0);
    checkVal("basic_upper_zero", |points[4095:48], 0);

    // Backpressure in HOLD
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      inValid = 1'b1; inX = 8'(8'h40 + i); inY = 8'(8'h80 + i); inLast = 1'b1;
    end
    @(posedge clk); #1;
    checkVal("bp_points", points[47:0], 64'hC801_0507_0A14);
    checkVal("bp_ss", ss, 3);
    checkVal("bp_upper_zero", |points[4095:48], 0);
    inValid = 1'b0; inLast = 1'b0;
    pulseConsume();
    checkVal("consume_points_zero", |points, 0);
    checkVal("consume_ready", inReady, 1);
    checkVal("consume_valid", pointsValid, 0);
    checkVal("consume_ss", ss, 0);
    sendPoint(8'h11, 8'h22, 1'b0);
    checkVal("after_consume_slot0", points[15:0], 16'h1122);
    sendPoint(8'h33, 8'h44, 1'b1);
    checkVal("after_consume_ss", ss, 2);
    checkVal("after_consume_slots", points[31:0], 32'h3344_1122);
    pulseConsume();

    // Stray consume during FILL
    sendPoint(8'h01, 8'h02, 1'b0);
    sendPoint(8'h03, 8'h04, 1'b0);
    pulseConsume();
    checkVal("stray_points", points[31:0], 32'h0304_0102);
    checkVal("stray_valid", pointsValid, 0);
    checkVal("stray_ss", ss, 0);
    sendPoint(8'h05, 8'h06, 1'b1);
    checkVal("stray_done_points", points[47:0], 64'h0506_0304_0102);
    checkVal("stray_done_ss", ss, 3);
    pulseConsume();

    // Mid-frame reset after 4 points
    for (int i = 0; i < 4; i++) sendPoint(8'(i + 1), 8'(i + 9), 1'b0);
    @(negedge clk); rst = 1'b1; #1;
    checkVal("midrst_points_zero", |points, 0);
    checkVal("midrst_ready", inReady, 1);
    checkVal("midrst_ss", ss, 0);
    @(negedge clk); rst = 1'b0;
    sendPoint(8'hAA, 8'hBB, 1'b0);
    sendPoint(8'hCC, 8'hDD, 1'b1);
    checkVal("midrst_new_ss", ss, 2);
    checkVal("midrst_new_slots", points[31:0], 32'hCCDD_AABB);
    checkVal("midrst_upper_zero", |points[4095:32], 0);

    // Reset during HOLD discards the frame
    @(negedge clk); rst = 1'b1; #1;
    checkVal("holdrst_valid", pointsValid, 0);
    checkVal("holdrst_points_zero", |points, 0);
    @(negedge clk); rst = 1'b0;

    // Full 256-point frame, in_last never set
    for (int i = 0; i < 255; i++) sendPoint(8'(i), ~8'(i), 1'b0);
    checkVal("full_255_valid", pointsValid, 0);
    sendPoint(8'hFF, 8'h00, 1'b0);
    checkVal("full_valid", pointsValid, 1);
    checkVal("full_ss", ss, 0);
    checkVal("full_slot0", points[15:0], 16'h00FF);
    checkVal("full_slot128", points[128*16 +: 16], 16'h807F);
    checkVal("full_slot255", points[4095:4080], 16'hFF00);
    pulseConsume();

    // in_last on the 256th point is one exit
    for (int i = 0; i < 255; i++) sendPoint(8'h12, 8'(i), 1'b0);
    sendPoint(8'h77, 8'h66, 1'b1);
    checkVal("last255_valid", pointsValid, 1);
    checkVal("last255_ss", ss, 0);
    checkVal("last255_slot255", points[4095:4080], 16'h7766);
    pulseConsume();
    sendPoint(8'h9A, 8'hBC, 1'b0);
    checkVal("wrap_slot0", points[15:0], 16'h9ABC);
    checkVal("wrap_slot1_zero", points[31:16], 16'h0000);
    sendPoint(8'h01, 8'h01, 1'b1);
    pulseConsume();

`ifdef POINT_LOADER_XMINMAX_EN
    sendPoint(8'd9, 8'd1, 1'b0);
    sendPoint(8'd3, 8'd2, 1'b0);
    sendPoint(8'd9, 8'd3, 1'b0);
    sendPoint(8'd3, 8'd4, 1'b1);
    checkVal("xmin", xMinPoint, 16'h0302);
    checkVal("xmax", xMaxPoint, 16'h0901);
    pulseConsume();
    checkVal("xmin_clear", xMinPoint, 16'h0000);
    checkVal("xmax_clear", xMaxPoint, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
